ex_data_serializer: RTL and testbench



---
 rtl/ex_port_pkg.sv | 11 +
 rtl/clk_en_div.sv | 28 ++
 rtl/ex_data_serializer.sv | 134 +++++++++++++
 tb/tb_ex_data_serializer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ex_port_pkg.sv
// Shared types and helpers for the external-port peripherals of the 6502 subsystem.
package ex_port_pkg;

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, GAP} state_e;

  function automatic int unsigned calc_half_div(input int unsigned clk_hz,
                                                input int unsigned sclk_hz);
    return clk_hz / (2 * sclk_hz);
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// Clock-enable divider: tick_o is high on the last cycle of every DIV-cycle period.
module clk_en_div #(
  parameter int unsigned DIV = 25
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/ex_data_serializer.sv
// Shifts the 6502 ex_data register out MSB-first to a 74HC595-style shift register,
// re-sending only when the value changes (plus one forced frame after reset).
module ex_data_serializer #(
  parameter int unsigned FPGAClkSpeed  = 50000000,
  parameter int unsigned ShiftClkSpeed = 1000000,
  parameter int unsigned data_width    = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [data_width-1:0] data_i,
  output logic                  sr_clk_o,
  output logic                  sr_data_o,
  output logic                  sr_latch_o,
  output logic                  busy_o
);
  import ex_port_pkg::*;

  localparam int unsigned HALF_DIV = calc_half_div(FPGAClkSpeed, ShiftClkSpeed);
  localparam int unsigned BW       = (data_width > 1) ? $clog2(data_width) : 1;

  if (HALF_DIV == 0) begin : g_div_check
    $error("ex_data_serializer: ShiftClkSpeed too high, half period below one clock");
  end

  state_e                state_q, state_d;
  logic [data_width-1:0] shadow_q, shadow_d;
  logic [data_width-1:0] last_q, last_d;
  logic                  force_q, force_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  sr_clk_q, sr_clk_d;
  logic                  sr_data_q, sr_data_d;
  logic                  sr_latch_q, sr_latch_d;
  logic                  busy_q, busy_d;
  logic                  tick;
  logic                  clear;

  // Restart the half-period count on every state entry so each phase is exactly HALF_DIV long.
  assign clear = (state_d != state_q);

  clk_en_div #(.DIV(HALF_DIV)) u_div (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear),
    .tick_o  (tick)
  );

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    last_d     = last_q;
    force_d    = force_q;
    bit_cnt_d  = bit_cnt_q;
    sr_clk_d   = sr_clk_q;
    sr_data_d  = sr_data_q;
    sr_latch_d = sr_latch_q;
    busy_d     = busy_q;
    unique case (state_q)
      IDLE: begin
        if ((data_i != last_q) || force_q) begin
          shadow_d  = data_i;
          last_d    = data_i;
          force_d   = 1'b0;
          bit_cnt_d = BW'(data_width - 1);
          sr_data_d = data_i[data_width-1];
          busy_d    = 1'b1;
          state_d   = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (tick) begin
          sr_clk_d = 1'b1;
          state_d  = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (tick) begin
          sr_clk_d = 1'b0;
          if (bit_cnt_q == '0) begin
            sr_latch_d = 1'b1;
            state_d    = LATCH;
          end else begin
            bit_cnt_d = bit_cnt_q - BW'(1);
            shadow_d  = shadow_q << 1;
            sr_data_d = shadow_d[data_width-1];
            state_d   = SHIFT_LO;
          end
        end
      end
      LATCH: begin
        if (tick) begin
          sr_latch_d = 1'b0;
          state_d    = GAP;
        end
      end
      GAP: begin
        if (tick) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      last_q     <= '0;
      force_q    <= 1'b1;
      bit_cnt_q  <= '0;
      sr_clk_q   <= 1'b0;
      sr_data_q  <= 1'b0;
      sr_latch_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      last_q     <= last_d;
      force_q    <= force_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_clk_q   <= sr_clk_d;
      sr_data_q  <= sr_data_d;
      sr_latch_q <= sr_latch_d;
      busy_q     <= busy_d;
    end
  end

  assign sr_clk_o   = sr_clk_q;
  assign sr_data_o  = sr_data_q;
  assign sr_latch_o = sr_latch_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_ex_data_serializer.sv
// Directed bench for ex_data_serializer: default 1 MHz shift clock plus a HalfDiv=1 instance.
module tb_ex_data_serializer;

  logic       clk = 1'b0;
  logic       rst0, rst1;
  logic [7:0] data0, data1;
  logic       sc0, sd0, sl0, sb0;
  logic       sc1, sd1, sl1, sb1;
  int         checks = 0;
  int         errors = 0;

  always #10 clk = ~clk;

  ex_data_serializer #(.FPGAClkSpeed(50000000), .ShiftClkSpeed(1000000), .data_width(8)) dut0 (
    .clk_i(clk), .reset_i(rst0), .data_i(data0),
    .sr_clk_o(sc0), .sr_data_o(sd0), .sr_latch_o(sl0), .busy_o(sb0)
  );

  ex_data_serializer #(.FPGAClkSpeed(50000000), .ShiftClkSpeed(25000000), .data_width(8)) dut1 (
    .clk_i(clk), .reset_i(rst1), .data_i(data1),
    .sr_clk_o(sc1), .sr_data_o(sd1), .sr_latch_o(sl1), .busy_o(sb1)
  );

  // Observes one instance for up to limit cycles (sampled on falling edges), optionally
  // changing its data input at cycles c1n/c2n; stops once busy has risen and fallen.
  task automatic capture(input int which, input int limit,
                         input int c1n, input logic [7:0] c1v,
                         input int c2n, input logic [7:0] c2v,
                         output logic [7:0] bits, output int rises, output int first_rise,
                         output int latches, output int latch_w, output logic [7:0] latched,
                         output int busy_n, output logic done);
    logic pc, pl, seen, sc, sd, sl, sb;
    bits = '0; rises = 0; first_rise = -1; latches = 0; latch_w = 0;
    latched = '0; busy_n = 0; done = 1'b0; seen = 1'b0;
    pc = (which == 0) ? sc0 : sc1;
    pl = (which == 0) ? sl0 : sl1;
    for (int n = 1; n <= limit && !done; n++) begin
      @(negedge clk);
      sc = (which == 0) ? sc0 : sc1;
      sd = (which == 0) ? sd0 : sd1;
      sl = (which == 0) ? sl0 : sl1;
      sb = (which == 0) ? sb0 : sb1;
      if (sc && !pc) begin
        bits = {bits[6:0], sd};
        rises++;
        if (first_rise < 0) first_rise = n;
      end
      if (sl) latch_w++;
      if (sl && !pl) begin
        latches++;
        latched = bits;
      end
      if (sb) begin
        busy_n++;
        seen = 1'b1;
      end else if (seen) begin
        done = 1'b1;
      end
      pc = sc;
      pl = sl;
      if (n == c1n) begin if (which == 0) data0 = c1v; else data1 = c1v; end
      if (n == c2n) begin if (which == 0) data0 = c2v; else data1 = c2v; end
    end
  endtask

  task automatic test_reset();
    checks++; if (sc0 !== 1'b0) begin errors++; $display("FAIL reset_sr_clk: got %b expected 0", sc0); end
    checks++; if (sd0 !== 1'b0) begin errors++; $display("FAIL reset_sr_data: got %b expected 0", sd0); end
    checks++; if (sl0 !== 1'b0) begin errors++; $display("FAIL reset_sr_latch: got %b expected 0", sl0); end
    checks++; if (sb0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", sb0); end
  endtask

  task automatic test_forced_frame();
    logic [7:0] bits, latched; int rises, fr, lat, lw, bn; logic done;
    data0 = 8'h00;
    rst0  = 1'b0;
    capture(0, 1000, -1, 8'h00, -1, 8'h00, bits, rises, fr, lat, lw, latched, bn, done);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL forced_done: got %b expected 1", done); end
    checks++; if (rises !== 8) begin errors++; $display("FAIL forced_rises: got %0d expected 8", rises); end
    checks++; if (bits !== 8'h00) begin errors++; $display("FAIL forced_bits: got %h expected 00", bits); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL forced_latches: got %0d expected 1", lat); end
    checks++; if (lw !== 25) begin errors++; $display("FAIL forced_latch_width: got %0d expected 25", lw); end
    checks++; if (bn !== 450) begin errors++; $display("FAIL forced_busy_len: got %0d expected 450", bn); end
  endtask

  task automatic test_a5();
    logic [7:0] bits, latched; int rises, fr, lat, lw, bn; logic done;
    data0 = 8'hA5;
    capture(0, 1000, -1, 8'h00, -1, 8'h00, bits, rises, fr, lat, lw, latched, bn, done);
    checks++; if (bits !== 8'hA5) begin errors++; $display("FAIL a5_bits: got %h expected a5", bits); end
    checks++; if (fr !== 26) begin errors++; $display("FAIL a5_first_rise: got %0d expected 26", fr); end
    checks++; if (latched !== 8'hA5) begin errors++; $display("FAIL a5_latched: got %h expected a5", latched); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits, latched; int rises, fr, lat, lw, bn; logic done;
    data0 = 8'h01;
    capture(0, 1000, 100, 8'h3C, 200, 8'hF0, bits, rises, fr, lat, lw, latched, bn, done);
    checks++; if (latched !== 8'h01) begin errors++; $display("FAIL b2b_first_latched: got %h expected 01", latched); end
    capture(0, 1000, -1, 8'h00, -1, 8'h00, bits, rises, fr, lat, lw, latched, bn, done);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %b expected 1", done); end
    checks++; if (latched !== 8'hF0) begin errors++; $display("FAIL b2b_second_latched: got %h expected f0", latched); end
    capture(0, 600, -1, 8'h00, -1, 8'h00, bits, rises, fr, lat, lw, latched, bn, done);
    checks++; if (rises !== 0) begin errors++; $display("FAIL b2b_no_third: got %0d rises expected 0", rises); end
  endtask

  task automatic test_hold();
    logic [7:0] bits, latched; int rises, fr, lat, lw, bn; logic done;
    data0 = 8'h5A;
    capture(0, 1000, -1, 8'h00, -1, 8'h00, bits, rises, fr, lat, lw, latched, bn, done);
    checks++; if (latched !== 8'h5A) begin errors++; $display("FAIL hold_latched: got %h expected 5a", latched); end
    capture(0, 2000, -1, 8'h00, -1, 8'h00, bits, rises, fr, lat, lw, latched, bn, done);
    checks++; if (rises !== 0) begin errors++; $display("FAIL hold_rises: got %0d expected 0", rises); end
    checks++; if (lat !== 0) begin errors++; $display("FAIL hold_latches: got %0d expected 0", lat); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] bits, latched; int rises, fr, lat, lw, bn; logic done;
    int r; int lp; logic pc;
    r = 0; lp = 0; pc = sc0;
    data0 = 8'hFF;
    for (int g = 0; g < 1000 && r < 4; g++) begin
      @(negedge clk);
      if (sc0 && !pc) r++;
      pc = sc0;
    end
    checks++; if (r !== 4) begin errors++; $display("FAIL midrst_reach_bit4: got %0d rises expected 4", r); end
    repeat (10) @(negedge clk);
    rst0 = 1'b1;
    #1;
    checks++; if (sc0 !== 1'b0) begin errors++; $display("FAIL midrst_sr_clk: got %b expected 0", sc0); end
    checks++; if (sd0 !== 1'b0) begin errors++; $display("FAIL midrst_sr_data: got %b expected 0", sd0); end
    checks++; if (sl0 !== 1'b0) begin errors++; $display("FAIL midrst_sr_latch: got %b expected 0", sl0); end
    checks++; if (sb0 !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", sb0); end
    repeat (40) begin
      @(negedge clk);
      if (sl0) lp++;
    end
    checks++; if (lp !== 0) begin errors++; $display("FAIL midrst_no_latch: got %0d expected 0", lp); end
    rst0 = 1'b0;
    capture(0, 1000, -1, 8'h00, -1, 8'h00, bits, rises, fr, lat, lw, latched, bn, done);
    checks++; if (rises !== 8) begin errors++; $display("FAIL midrst_after_rises: got %0d expected 8", rises); end
    checks++; if (latched !== 8'hFF) begin errors++; $display("FAIL midrst_after_latched: got %h expected ff", latched); end
    checks++; if (bn !== 450) begin errors++; $display("FAIL midrst_after_busy: got %0d expected 450", bn); end
  endtask

  task automatic test_halfdiv1();
    logic [7:0] bits, latched; int rises, fr, lat, lw, bn; logic done;
    data1 = 8'hC3;
    rst1  = 1'b0;
    capture(1, 100, -1, 8'h00, -1, 8'h00, bits, rises, fr, lat, lw, latched, bn, done);
    checks++; if (rises !== 8) begin errors++; $display("FAIL hd1_rises: got %0d expected 8", rises); end
    checks++; if (latched !== 8'hC3) begin errors++; $display("FAIL hd1_latched: got %h expected c3", latched); end
    checks++; if (bn !== 18) begin errors++; $display("FAIL hd1_busy_len: got %0d expected 18", bn); end
    checks++; if (lw !== 1) begin errors++; $display("FAIL hd1_latch_width: got %0d expected 1", lw); end
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    data0 = 8'h00; data1 = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    test_forced_frame();
    test_a5();
    test_back_to_back();
    test_hold();
    test_reset_midframe();
    test_halfdiv1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
